// File: rtl/fpdiv_share_arb_if.sv
// Purpose : handshake bundle between the lane FSMs, the shared divider and fpdiv_share_arb.
// Latency : none (wires only).
// Backpr. : req_* is valid/ready, div_* is valid/ready, rsp_* has no backpressure.
// Ports   : req_valid_i/req_a_i/req_b_i/req_ready_o    lane request side
//           div_valid_o/div_ready_i/div_a_o/div_b_o/div_tag_o   divider issue side
//           div_res_valid_i/div_res_i/div_res_tag_i      divider result side
//           rsp_valid_o/rsp_data_o/err_o                 lane response side
//           perf_grant_o/perf_stall_o                    only with DIVARB_PERF_EN
// Modports: master = arbiter, slave = lanes + divider environment.
interface fpdiv_share_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 5
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0][31:0]  req_a_i;
  logic [NUM_REQ-1:0][31:0]  req_b_i;
  logic [NUM_REQ-1:0]        req_ready_o;

  logic                      div_valid_o;
  logic                      div_ready_i;
  logic [31:0]               div_a_o;
  logic [31:0]               div_b_o;
  logic [TAG_W-1:0]          div_tag_o;

  logic                      div_res_valid_i;
  logic [31:0]               div_res_i;
  logic [TAG_W-1:0]          div_res_tag_i;

  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [31:0]               rsp_data_o;
  logic                      err_o;

`ifdef DIVARB_PERF_EN
  logic [NUM_REQ-1:0][15:0]  perf_grant_o;
  logic [15:0]               perf_stall_o;
`endif

  modport master (
`ifdef DIVARB_PERF_EN
    output perf_grant_o, perf_stall_o,
`endif
    input  req_valid_i, req_a_i, req_b_i,
    output req_ready_o,
    output div_valid_o, div_a_o, div_b_o, div_tag_o,
    input  div_ready_i,
    input  div_res_valid_i, div_res_i, div_res_tag_i,
    output rsp_valid_o, rsp_data_o, err_o
  );

  modport slave (
`ifdef DIVARB_PERF_EN
    input  perf_grant_o, perf_stall_o,
`endif
    output req_valid_i, req_a_i, req_b_i,
    input  req_ready_o,
    input  div_valid_o, div_a_o, div_b_o, div_tag_o,
    output div_ready_i,
    output div_res_valid_i, div_res_i, div_res_tag_i,
    input  rsp_valid_o, rsp_data_o, err_o
  );
endinterface

// File: rtl/fpdiv_share_arb.sv
// Purpose : round-robin share of one FP32 div/sqrt unit among NUM_REQ lanes, tag = {seq, lane id}.
// Latency : issue 0 cycles (combinational grant when div_ready_i=1); response 1 cycle after divider.
// Backpr. : divider stall freezes the granted request in HOLD; issue gated when MAX_INFLIGHT ops outstanding.
// Ports   : clk, rst (async active-high), bus (fpdiv_share_arb_if.master).
// Option  : define DIVARB_PERF_EN to add per-lane grant counters and a stall-cycle counter.
module fpdiv_share_arb #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int TAG_W        = 5
) (
  input  logic               clk,
  input  logic               rst,
  fpdiv_share_arb_if.master  bus
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int SEQW = TAG_W - IDW;
  localparam int NP2  = 1 << IDW;   // id space; entries >= NUM_REQ never count up
  localparam int CW   = 4;          // holds 0..15 outstanding ops

  typedef enum logic {ARB, HOLD} state_t;

  state_t            state;
  logic [IDW-1:0]    rr_ptr;
  logic [CW-1:0]     tot_inflight;
  logic [CW-1:0]     inflight [NP2];
  logic [SEQW-1:0]   seq      [NP2];

  logic [IDW-1:0]    hold_id;
  logic [31:0]       hold_a;
  logic [31:0]       hold_b;
  logic [TAG_W-1:0]  hold_tag;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first valid lane at or after rr_ptr.
  // ---------------------------------------------------------------------------
  logic              pick_vld;
  logic [IDW-1:0]    pick_id;
  int                idx;

  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_vld && bus.req_valid_i[idx]) begin
        pick_vld = 1'b1;
        pick_id  = IDW'(idx);
      end
    end
  end

  // Full is judged on the registered count only, so a response arriving in
  // the same cycle frees a slot for the next cycle, not this one.
  logic full;
  assign full = (tot_inflight >= CW'(MAX_INFLIGHT));

  // ---------------------------------------------------------------------------
  // Issue mux: live pick in ARB, frozen copy in HOLD. Reset forces it idle so
  // every output reads 0 while rst is high, even with lanes still requesting.
  // ---------------------------------------------------------------------------
  logic              issue_vld;
  logic [IDW-1:0]    issue_id;
  logic [31:0]       issue_a;
  logic [31:0]       issue_b;
  logic [TAG_W-1:0]  issue_tag;
  logic              accept;

  always_comb begin
    issue_vld = 1'b0;
    issue_id  = pick_id;
    issue_a   = bus.req_a_i[pick_id];
    issue_b   = bus.req_b_i[pick_id];
    issue_tag = {seq[pick_id], pick_id};
    if (state == HOLD) begin
      issue_vld = 1'b1;
      issue_id  = hold_id;
      issue_a   = hold_a;
      issue_b   = hold_b;
      issue_tag = hold_tag;
    end else begin
      issue_vld = pick_vld && !full;
    end
    if (rst) issue_vld = 1'b0;
  end

  assign accept          = issue_vld && bus.div_ready_i;
  assign bus.div_valid_o = issue_vld;
  assign bus.div_a_o     = issue_vld ? issue_a   : '0;
  assign bus.div_b_o     = issue_vld ? issue_b   : '0;
  assign bus.div_tag_o   = issue_vld ? issue_tag : '0;
  assign bus.req_ready_o = accept ? (NUM_REQ'(1) << issue_id) : '0;

  // ---------------------------------------------------------------------------
  // Response qualification: only lanes with something outstanding may answer.
  // ---------------------------------------------------------------------------
  logic [IDW-1:0] res_id;
  logic           res_ok;

  assign res_id = bus.div_res_tag_i[IDW-1:0];
  assign res_ok = bus.div_res_valid_i && (int'(res_id) < NUM_REQ) &&
                  (inflight[res_id] != '0);

  logic [IDW-1:0] next_ptr;
  assign next_ptr = (int'(issue_id) == NUM_REQ - 1) ? '0 : issue_id + IDW'(1);

  // ---------------------------------------------------------------------------
  // FSM, counters and registered response outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ARB;
      rr_ptr          <= '0;
      tot_inflight    <= '0;
      hold_id         <= '0;
      hold_a          <= '0;
      hold_b          <= '0;
      hold_tag        <= '0;
      for (int i = 0; i < NP2; i++) begin
        inflight[i] <= '0;
        seq[i]      <= '0;
      end
      bus.rsp_valid_o <= '0;
      bus.rsp_data_o  <= '0;
      bus.err_o       <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (issue_vld && !bus.div_ready_i) begin
            state    <= HOLD;
            hold_id  <= issue_id;
            hold_a   <= issue_a;
            hold_b   <= issue_b;
            hold_tag <= issue_tag;
          end
        end
        HOLD: begin
          if (bus.div_ready_i) state <= ARB;
        end
        default: state <= ARB;
      endcase

      if (accept) begin
        rr_ptr        <= next_ptr;
        seq[issue_id] <= seq[issue_id] + SEQW'(1);
      end

      // Accept and response on the same counter cancel out.
      for (int i = 0; i < NP2; i++) begin
        if (accept && (int'(issue_id) == i) && !(res_ok && (int'(res_id) == i)))
          inflight[i] <= inflight[i] + CW'(1);
        else if (res_ok && (int'(res_id) == i) && !(accept && (int'(issue_id) == i)))
          inflight[i] <= inflight[i] - CW'(1);
      end
      if (accept && !res_ok)
        tot_inflight <= tot_inflight + CW'(1);
      else if (res_ok && !accept)
        tot_inflight <= tot_inflight - CW'(1);

      bus.rsp_valid_o <= res_ok ? (NUM_REQ'(1) << res_id) : '0;
      if (res_ok) bus.rsp_data_o <= bus.div_res_i;
      if (bus.div_res_valid_i && !res_ok) bus.err_o <= 1'b1;
    end
  end

`ifdef DIVARB_PERF_EN
  logic [NUM_REQ-1:0][15:0] perf_grant_q;
  logic [15:0]              perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_grant_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (accept && (perf_grant_q[issue_id] != 16'hFFFF))
        perf_grant_q[issue_id] <= perf_grant_q[issue_id] + 16'd1;
      // Stall: stuck in HOLD, or a lane waiting while the divider is full.
      if (((state == HOLD) || ((state == ARB) && pick_vld && full)) &&
          (perf_stall_q != 16'hFFFF))
        perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  assign bus.perf_grant_o = perf_grant_q;
  assign bus.perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_fpdiv_share_arb.sv
module tb_fpdiv_share_arb;
  localparam int N   = 4;
  localparam int MAX = 4;
  localparam int TW  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpdiv_share_arb_if #(.NUM_REQ(N), .TAG_W(TW)) bus ();

  fpdiv_share_arb #(.NUM_REQ(N), .MAX_INFLIGHT(MAX), .TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  rv;
    logic        rdy;
    logic        resv;
    logic [4:0]  rtag;
    logic [31:0] rdat;
    logic        ev;
    logic [4:0]  etag;
    logic [3:0]  erdy;
    logic [3:0]  ersp;
    logic [31:0] edat;
    logic        eerr;
  } vec_t;

  function automatic vec_t mk(logic [3:0] rv, logic rdy, logic resv, logic [4:0] rtag,
                              logic [31:0] rdat, logic ev, logic [4:0] etag, logic [3:0] erdy,
                              logic [3:0] ersp, logic [31:0] edat, logic eerr);
    vec_t v;
    v.rv = rv; v.rdy = rdy; v.resv = resv; v.rtag = rtag; v.rdat = rdat;
    v.ev = ev; v.etag = etag; v.erdy = erdy; v.ersp = ersp; v.edat = edat; v.eerr = eerr;
    return v;
  endfunction

  // Reference model state for the random phase.
  int          m_rr, m_hold, m_lane;
  int          m_inf [N];
  int          m_seq [N];
  bit          m_err;
  bit          pend  [N];
  logic [31:0] pa    [N];
  logic [31:0] pb    [N];
  logic [4:0]  m_htag;
  logic [4:0]  dq [$];

  initial begin
    vec_t vecs [$];
    bus.req_valid_i     = '0;
    bus.div_ready_i     = 1'b0;
    bus.div_res_valid_i = 1'b0;
    bus.div_res_i       = '0;
    bus.div_res_tag_i   = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_a_i[i] = 32'h1000_0000 + 32'(i);
      bus.req_b_i[i] = 32'h2000_0000 + 32'(i);
    end

    //            rv   rdy res tag    data          ev tag    erdy  ersp  edat          err
    vecs.push_back(mk(4'hF, 1, 0, 5'h00, 32'h0,        1, 5'h00, 4'h1, 4'h0, 32'h0,        0));
    vecs.push_back(mk(4'hF, 1, 0, 5'h00, 32'h0,        1, 5'h01, 4'h2, 4'h0, 32'h0,        0));
    vecs.push_back(mk(4'hF, 1, 0, 5'h00, 32'h0,        1, 5'h02, 4'h4, 4'h0, 32'h0,        0));
    vecs.push_back(mk(4'hF, 1, 1, 5'h00, 32'h3F800000, 1, 5'h03, 4'h8, 4'h1, 32'h3F800000, 0));
    vecs.push_back(mk(4'hF, 1, 0, 5'h00, 32'h0,        1, 5'h04, 4'h1, 4'h0, 32'h0,        0));
    vecs.push_back(mk(4'hF, 1, 0, 5'h00, 32'h0,        0, 5'h00, 4'h0, 4'h0, 32'h0,        0));
    vecs.push_back(mk(4'hF, 1, 1, 5'h01, 32'h40000000, 0, 5'h00, 4'h0, 4'h2, 32'h40000000, 0));
    vecs.push_back(mk(4'hF, 1, 0, 5'h00, 32'h0,        1, 5'h05, 4'h2, 4'h0, 32'h0,        0));
    vecs.push_back(mk(4'h0, 1, 1, 5'h02, 32'h40400000, 0, 5'h00, 4'h0, 4'h4, 32'h40400000, 0));
    vecs.push_back(mk(4'h0, 1, 1, 5'h03, 32'h40800000, 0, 5'h00, 4'h0, 4'h8, 32'h40800000, 0));
    vecs.push_back(mk(4'h0, 1, 1, 5'h03, 32'h41000000, 0, 5'h00, 4'h0, 4'h0, 32'h0,        1));
    vecs.push_back(mk(4'h0, 1, 0, 5'h00, 32'h0,        0, 5'h00, 4'h0, 4'h0, 32'h0,        1));
    vecs.push_back(mk(4'h4, 0, 0, 5'h00, 32'h0,        1, 5'h06, 4'h0, 4'h0, 32'h0,        1));
    vecs.push_back(mk(4'h6, 0, 0, 5'h00, 32'h0,        1, 5'h06, 4'h0, 4'h0, 32'h0,        1));
    vecs.push_back(mk(4'h6, 0, 0, 5'h00, 32'h0,        1, 5'h06, 4'h0, 4'h0, 32'h0,        1));
    vecs.push_back(mk(4'h6, 1, 0, 5'h00, 32'h0,        1, 5'h06, 4'h4, 4'h0, 32'h0,        1));
    vecs.push_back(mk(4'h2, 1, 0, 5'h00, 32'h0,        1, 5'h09, 4'h2, 4'h0, 32'h0,        1));
    vecs.push_back(mk(4'h0, 1, 1, 5'h04, 32'h3F000000, 0, 5'h00, 4'h0, 4'h1, 32'h3F000000, 1));
    vecs.push_back(mk(4'h1, 0, 0, 5'h00, 32'h0,        1, 5'h08, 4'h0, 4'h0, 32'h0,        1));

    // Reset state.
    #2;
    chk("rst_div_valid", 64'(bus.div_valid_o), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_err",       64'(bus.err_o),       64'd0);
    step();
    rst = 1'b0;

    for (int r = 0; r < vecs.size(); r++) begin
      bus.req_valid_i     = vecs[r].rv;
      bus.div_ready_i     = vecs[r].rdy;
      bus.div_res_valid_i = vecs[r].resv;
      bus.div_res_tag_i   = vecs[r].rtag;
      bus.div_res_i       = vecs[r].rdat;
      #1;
      chk($sformatf("v%0d_div_valid", r), 64'(bus.div_valid_o), 64'(vecs[r].ev));
      chk($sformatf("v%0d_req_ready", r), 64'(bus.req_ready_o), 64'(vecs[r].erdy));
      if (vecs[r].ev) begin
        chk($sformatf("v%0d_tag", r), 64'(bus.div_tag_o), 64'(vecs[r].etag));
        chk($sformatf("v%0d_a", r), 64'(bus.div_a_o), 64'(32'h1000_0000 + 32'(vecs[r].etag[1:0])));
        chk($sformatf("v%0d_b", r), 64'(bus.div_b_o), 64'(32'h2000_0000 + 32'(vecs[r].etag[1:0])));
      end
      step();
      chk($sformatf("v%0d_rsp_valid", r), 64'(bus.rsp_valid_o), 64'(vecs[r].ersp));
      if (vecs[r].ersp != 4'h0)
        chk($sformatf("v%0d_rsp_data", r), 64'(bus.rsp_data_o), 64'(vecs[r].edat));
      chk($sformatf("v%0d_err", r), 64'(bus.err_o), 64'(vecs[r].eerr));
    end

    // DUT is now in HOLD on lane0 with 3 ops outstanding: reset mid-op.
    bus.div_res_valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("hrst_div_valid", 64'(bus.div_valid_o), 64'd0);
    chk("hrst_tag",       64'(bus.div_tag_o),   64'd0);
    chk("hrst_req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("hrst_err",       64'(bus.err_o),       64'd0);
    step();
    rst = 1'b0;
    bus.req_valid_i = 4'h1;
    bus.div_ready_i = 1'b1;
    #1;
    chk("post_rst_valid", 64'(bus.div_valid_o), 64'd1);
    chk("post_rst_tag",   64'(bus.div_tag_o),   64'h00);
    chk("post_rst_ready", 64'(bus.req_ready_o), 64'h1);
    step();

    // Randomized phase against a transaction-level model.
    bus.req_valid_i = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_rr = 0; m_hold = -1; m_err = 0; m_htag = '0;
    for (int i = 0; i < N; i++) begin
      m_inf[i] = 0; m_seq[i] = 0; pend[i] = 0; pa[i] = '0; pb[i] = '0;
    end
    dq.delete();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit          exp_vld, acc, res_ok;
      logic [4:0]  exp_tag, rtag;
      logic [31:0] rdat;
      int          tot, rid;

      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1; pa[i] = $urandom; pb[i] = $urandom;
        end
        bus.req_valid_i[i] = pend[i];
        bus.req_a_i[i]     = pa[i];
        bus.req_b_i[i]     = pb[i];
      end
      bus.div_ready_i = ($urandom_range(0, 3) != 0);

      bus.div_res_valid_i = 1'b0;
      rtag = '0;
      rdat = $urandom;
      if (dq.size() > 0 && $urandom_range(0, 2) == 0) begin
        rtag = dq.pop_front();
        bus.div_res_valid_i = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        rtag = 5'($urandom_range(0, 31));
        bus.div_res_valid_i = 1'b1;
      end
      bus.div_res_tag_i = rtag;
      bus.div_res_i     = rdat;

      tot = 0;
      for (int i = 0; i < N; i++) tot += m_inf[i];
      exp_vld = 0; m_lane = 0; exp_tag = '0;
      if (m_hold >= 0) begin
        exp_vld = 1; m_lane = m_hold; exp_tag = m_htag;
      end else if (tot < MAX) begin
        for (int k = 0; k < N; k++) begin
          if (!exp_vld && pend[(m_rr + k) % N]) begin
            exp_vld = 1; m_lane = (m_rr + k) % N;
          end
        end
        exp_tag = 5'((m_seq[m_lane] << 2) | m_lane);
      end
      acc = exp_vld && bus.div_ready_i;

      #1;
      chk("rnd_div_valid", 64'(bus.div_valid_o), 64'(exp_vld));
      chk("rnd_req_ready", 64'(bus.req_ready_o), acc ? 64'(1 << m_lane) : 64'd0);
      if (exp_vld) begin
        chk("rnd_tag", 64'(bus.div_tag_o), 64'(exp_tag));
        chk("rnd_a",   64'(bus.div_a_o),   64'(pa[m_lane]));
        chk("rnd_b",   64'(bus.div_b_o),   64'(pb[m_lane]));
      end

      rid = int'(rtag[1:0]);
      res_ok = bus.div_res_valid_i && (m_inf[rid] > 0);
      if (acc) begin
        m_inf[m_lane]++;
        m_seq[m_lane] = (m_seq[m_lane] + 1) % 8;
        m_rr = (m_lane + 1) % N;
        pend[m_lane] = 0;
        m_hold = -1;
        dq.push_back(exp_tag);
      end else if (exp_vld) begin
        m_hold = m_lane; m_htag = exp_tag;
      end
      if (res_ok) m_inf[rid]--;
      else if (bus.div_res_valid_i) m_err = 1;

      step();
      chk("rnd_rsp_valid", 64'(bus.rsp_valid_o), res_ok ? 64'(1 << rid) : 64'd0);
      if (res_ok) chk("rnd_rsp_data", 64'(bus.rsp_data_o), 64'(rdat));
      chk("rnd_err", 64'(bus.err_o), 64'(m_err));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
